// File: rtl/btn_debouncer.sv
// Push-button conditioner: multi-flop synchroniser followed by a counter-based
// debounce FSM producing a clean level and single-cycle rise/fall pulses.
module btn_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        WAIT_HIGH   = 2'd1,
        HIGH_STABLE = 2'd2,
        WAIT_LOW    = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Counter is cleared on every WAIT entry and on completion, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            LOW_STABLE: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH_STABLE;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            HIGH_STABLE: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW_STABLE;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = LOW_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer: expected pulses are queued with their due
// cycle when the stimulus is driven, then popped and compared every cycle.
module tb_btn_debouncer;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned CW   = 3;
    localparam int          LAT  = SYNC + DEB + 1;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic level;
    logic rise;
    logic fall;

    typedef struct {
        bit is_rise;
        int due;
    } ev_t;

    ev_t exp_q[$];
    bit  exp_level;
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_fail   = 0;

    btn_debouncer #(
        .SYNC_STAGES    (SYNC),
        .CNT_WIDTH      (CW),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .level(level),
        .rise (rise),
        .fall (fall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %b, expected %b", tag, cyc, got, exp);
        end
    endtask

    // Advance n cycles; at each falling edge pop any pulse due now and compare.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            ev_t e;
            bit  due;
            @(negedge clk);
            due = 1'b0;
            e   = '{1'b0, 0};
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e         = exp_q.pop_front();
                due       = 1'b1;
                exp_level = e.is_rise;
            end
            check("rise",  rise,  due &&  e.is_rise);
            check("fall",  fall,  due && !e.is_rise);
            check("level", level, exp_level);
        end
    endtask

    task automatic drive_btn(input logic v, input bit expect_edge);
        btn = v;
        if (expect_edge) exp_q.push_back('{v, cyc + LAT});
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_level = 1'b0;
        run(1);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        btn       = 1'b0;
        exp_level = 1'b0;
        run(3);
        rst = 1'b0;
        run(3);

        // Clean press, then clean release.
        drive_btn(1'b1, 1'b1);
        run(12);
        drive_btn(1'b0, 1'b1);
        run(12);

        // Bounce: 2 high, 1 low, 3 high, then low -> nothing.
        drive_btn(1'b1, 1'b0);
        run(2);
        drive_btn(1'b0, 1'b0);
        run(1);
        drive_btn(1'b1, 1'b0);
        run(3);
        drive_btn(1'b0, 1'b0);
        run(10);

        // Boundary: 5 btn cycles high gives exactly 4 samples in WAIT_HIGH.
        drive_btn(1'b1, 1'b1);
        run(5);
        drive_btn(1'b0, 1'b1);
        run(12);

        // 4 cycles high is one sample short; re-press must restart the count.
        drive_btn(1'b1, 1'b0);
        run(4);
        drive_btn(1'b0, 1'b0);
        run(1);
        drive_btn(1'b1, 1'b1);
        run(10);
        drive_btn(1'b0, 1'b1);
        run(10);

        // Reset mid-debounce with btn held high.
        drive_btn(1'b1, 1'b0);
        run(4);
        pulse_reset();
        exp_q.push_back('{1'b1, cyc + LAT});
        run(10);
        drive_btn(1'b0, 1'b1);
        run(10);

        // Back-to-back press/release/press, 10 cycles each.
        drive_btn(1'b1, 1'b1);
        run(10);
        drive_btn(1'b0, 1'b1);
        run(10);
        drive_btn(1'b1, 1'b1);
        run(10);
        drive_btn(1'b0, 1'b1);
        run(10);

        // Reset on the completion cycle: reset wins, then a fresh rise follows.
        drive_btn(1'b1, 1'b1);
        run(6);
        pulse_reset();
        exp_q.push_back('{1'b1, cyc + LAT});
        run(10);

        // Reset while level is high and btn still held.
        pulse_reset();
        exp_q.push_back('{1'b1, cyc + LAT});
        run(10);
        drive_btn(1'b0, 1'b1);
        run(10);

        check("pending_empty", exp_q.size() == 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
